serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor: computes `a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtracting counterpart of the team's adder cells. It serves area-constrained datapaths that can spend WIDTH+2 cycles per operation instead of a WIDTH-bit ripple subtractor. A start/busy/done handshake sits between it and its controller.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/F_Subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sersub_state_e;

   localparam int SERSUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/F_Subtractor.sv
// Combinational full-subtractor cell: D = A - B - Bin, Bout is the borrow out.
module F_Subtractor (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic D,
   output logic Bout
);

   assign D    = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell plus registered borrow.
// SERIAL_SUBTRACTOR_OVF_EN enables the signed overflow flag; otherwise ovf is tied to 0.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = SERSUB_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sersub_state_e    state, state_nxt;
   logic [WIDTH-1:0] sa, sb;
   logic [WIDTH-2:0] sr;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d, bnext;
   logic [WIDTH-1:0] res;
   logic             last_bit;

   F_Subtractor u_cell (
      .A   (sa[0]),
      .B   (sb[0]),
      .Bin (br),
      .D   (d),
      .Bout(bnext)
   );

   // sr holds the WIDTH-1 bits already produced; the current bit completes the word
   assign res      = {d, sr};
   assign last_bit = (state == RUN) && (cnt == LAST);

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         sr    <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         diff  <= '0;
         bout  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
         end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= res[WIDTH-1:1];
            br  <= bnext;
            cnt <= cnt + 1'b1;
            if (last_bit) begin
               diff <= res;
               bout <= bnext;
            end
         end
      end
   end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic a_msb, b_msb, ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
         end
         // d is the final difference MSB on the last RUN cycle
         if (last_bit) ovf_q <= (a_msb ^ b_msb) & (a_msb ^ d);
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         bin;
   logic         busy, done, bout, ovf;
   logic [W-1:0] diff;

   int errs   = 0;
   int checks = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .busy (busy),
      .done (done),
      .diff (diff),
      .bout (bout),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_ovf(input logic bit_ovf);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      return bit_ovf;
`else
      return 1'b0 & bit_ovf;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start sampled at edge T; checks busy window T+1..T+8, done at T+9, idle at T+10
   task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vbin, input logic [W-1:0] ed, input logic eb,
                         input logic eo);
      int bad;
      @(negedge clk);
      a = va; b = vb; bin = vbin; start = 1'b1;
      tick();
      start = 1'b0;
      bad = 0;
      for (int i = 1; i <= W; i++) begin
         if (!(busy === 1'b1 && done === 1'b0)) bad++;
         if (i < W) tick();
      end
      chk({tag, "_busy_window"}, bad, 0);
      tick();
      chk({tag, "_done"}, {busy, done}, 2'b01);
      chk({tag, "_diff"}, diff, ed);
      chk({tag, "_bout"}, bout, eb);
      chk({tag, "_ovf"}, ovf, exp_ovf(eo));
      tick();
      chk({tag, "_idle"}, {busy, done}, 2'b00);
   endtask

   typedef struct {
      logic [W-1:0] a, b;
      logic         bin;
      logic [W-1:0] d;
      logic         bo, ov;
   } vec_t;

   vec_t hold_v[4];

   initial begin
      int bad, got, last_done, cyc;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      tick(); tick();
      chk("rst_state", {busy, done, diff, bout, ovf}, '0);
      @(negedge clk); rst = 1'b0;

      run_op("v5a_23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
      run_op("v10_20", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
      run_op("v00_00_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      run_op("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      run_op("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

      // start pulse during RUN must be ignored
      @(negedge clk);
      a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      a = 8'hFF; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 4; i < W + 1; i++) tick();
      chk("ign_done", done, 1'b1);
      chk("ign_diff", diff, 8'h37);
      tick();
      chk("ign_no_rerun", {busy, done}, 2'b00);

      // reset in the 4th RUN cycle discards the operation
      @(negedge clk);
      a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("rst_mid_busy_before", busy, 1'b1);
      rst = 1'b1;
      tick();
      chk("rst_mid_outputs", {busy, done, diff, bout, ovf}, '0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) bad++;
         tick();
      end
      chk("rst_mid_no_done", bad, 0);

      // start held high: back-to-back operations every W+2 cycles
      hold_v[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
      hold_v[1] = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0};
      hold_v[2] = '{8'hC8, 8'h64, 1'b1, 8'h63, 1'b0, 1'b1};
      hold_v[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      @(negedge clk);
      a = hold_v[0].a; b = hold_v[0].b; bin = hold_v[0].bin; start = 1'b1;
      tick();
      a = hold_v[1].a; b = hold_v[1].b; bin = hold_v[1].bin;
      cyc = 1;
      last_done = -1;
      for (int k = 0; k < 4; k++) begin
         got = 0;
         for (int i = 0; i < 3 * W && !got; i++) begin
            tick();
            cyc++;
            if (done === 1'b1) got = 1;
         end
         chk($sformatf("hold%0d_done_seen", k), got, 1);
         if (!got) break;
         if (last_done >= 0) chk($sformatf("hold%0d_period", k), cyc - last_done, W + 2);
         last_done = cyc;
         chk($sformatf("hold%0d_diff", k), diff, hold_v[k].d);
         chk($sformatf("hold%0d_bout", k), bout, hold_v[k].bo);
         chk($sformatf("hold%0d_ovf", k), ovf, exp_ovf(hold_v[k].ov));
         tick(); tick();
         cyc += 2;
         if (k + 2 < 4) begin
            a = hold_v[k+2].a; b = hold_v[k+2].b; bin = hold_v[k+2].bin;
         end else begin
            start = 1'b0;
         end
      end
      tick(); tick();
      chk("hold_end_idle", {busy, done}, 2'b00);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
